// File: rtl/twos_complement_serial.sv
// Bit-serial two's complement unit: pass, negate or absolute value, one bit per cycle, LSB first.
// Define TWOS_COMPLEMENT_SERIAL_OVF_EN to add the ovf port (negation of the most-negative value).
module twos_complement_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op;
    logic [1:0]       op_mode;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic negate;
    logic bit_in;
    logic bit_res;

    // Mode 11 is reserved and falls through to pass.
    always_comb begin
        negate  = (op_mode == 2'b01) || ((op_mode == 2'b10) && op[WIDTH-1]);
        bit_in  = op[cnt];
        bit_res = negate ? (~bit_in ^ carry) : bit_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op      <= '0;
            op_mode <= 2'b00;
            cnt     <= '0;
            carry   <= 1'b1;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op      <= in;
                        op_mode <= mode;
                        out     <= '0;
                        cnt     <= '0;
                        carry   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RUN;
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
                        ovf     <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    out[cnt] <= bit_res;
                    if (negate) begin
                        carry <= ~bit_in & carry;
                    end
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
                        ovf   <= negate && (op == MOST_NEG);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
